biphase_mark_tx: RTL and testbench

Parametrised biphase-mark line encoder for the optical transmit path on fpga1. It accepts parallel words over a valid/ready handshake and serialises them MSB-first. Each bit occupies two half-cells, each lasting a programmable number of clocks, and the block drives the optical line directly. It subsumes the single-bit combinational encoder: it owns the previous-level state, bit timing, framing and an optional sync preamble.

---
 rtl/biphase_pkg.sv | 18 +
 rtl/biphase_mark_tx_half_cell_timer.sv | 29 ++
 rtl/biphase_mark_tx.sv | 128 ++++++++++++
 tb/tb_biphase_mark_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/biphase_pkg.sv
// Shared definitions for the biphase-mark transmitter and the future receiver.
// The PREAMBLE state only exists when BIPHASE_PREAMBLE_EN is defined.
package biphase_pkg;

    localparam int PREAMBLE_HALF_CELLS = 8;
    // Bit 7-k set means the line toggles on entry to preamble half-cell k.
    localparam logic [7:0] PREAMBLE_TOGGLES = 8'b1000_1000;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
`ifdef BIPHASE_PREAMBLE_EN
        PREAMBLE    = 2'd1,
`endif
        FIRST_HALF  = 2'd2,
        SECOND_HALF = 2'd3
    } tx_state_t;

endpackage

// File: rtl/biphase_mark_tx_half_cell_timer.sv
// Half-cell timer: strobes on the last clock of each HALF_BIT_CLKS-long half-cell.
// A restart forces the count back to the start of a half-cell.
module half_cell_timer #(
    parameter int HALF_BIT_CLKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic strobe
);

    localparam int CW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CLKS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign strobe = (cnt == LAST);

endmodule

// File: rtl/biphase_mark_tx.sv
// Biphase-mark line encoder: serialises DATA_WIDTH-bit words MSB-first onto the line.
// Define BIPHASE_PREAMBLE_EN to precede every word with an 8 half-cell sync preamble.
module biphase_mark_tx #(
    parameter int DATA_WIDTH    = 20,
    parameter int HALF_BIT_CLKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    output logic                  data_ready_out,
    output logic                  biphase_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    import biphase_pkg::*;

    localparam int BW = $clog2(DATA_WIDTH + 1);

    tx_state_t             state, state_d;
    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic [BW-1:0]         bit_cnt, bit_cnt_d;
    logic                  level, level_d;
`ifdef BIPHASE_PREAMBLE_EN
    logic [2:0]            pre_cnt, pre_cnt_d;
`endif
    logic                  strobe;
    logic                  restart;
    logic                  last_half;
    logic                  ready;
    logic                  accept;

    assign restart = (state == IDLE);

    half_cell_timer #(
        .HALF_BIT_CLKS(HALF_BIT_CLKS)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .strobe (strobe)
    );

    // The final clock of a word doubles as an accept slot so words can run back-to-back.
    assign last_half = (state == SECOND_HALF) && strobe && (bit_cnt == BW'(1));
    assign ready     = (state == IDLE) || last_half;
    assign accept    = data_valid_in && ready;

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        level_d   = level;
`ifdef BIPHASE_PREAMBLE_EN
        pre_cnt_d = pre_cnt;
`endif
        case (state)
`ifdef BIPHASE_PREAMBLE_EN
            PREAMBLE: begin
                if (strobe) begin
                    if (pre_cnt == 3'(PREAMBLE_HALF_CELLS - 1)) begin
                        state_d = FIRST_HALF;
                        level_d = ~level;
                    end else begin
                        pre_cnt_d = pre_cnt + 3'd1;
                        level_d   = level ^ PREAMBLE_TOGGLES[3'(PREAMBLE_HALF_CELLS - 2) - pre_cnt];
                    end
                end
            end
`endif
            FIRST_HALF: begin
                if (strobe) begin
                    state_d = SECOND_HALF;
                    level_d = level ^ shreg[DATA_WIDTH-1];
                end
            end
            SECOND_HALF: begin
                if (strobe) begin
                    shreg_d   = shreg << 1;
                    bit_cnt_d = bit_cnt - BW'(1);
                    if (bit_cnt == BW'(1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FIRST_HALF;
                        level_d = ~level;
                    end
                end
            end
            default: begin
            end
        endcase

        if (accept) begin
            shreg_d   = data_in;
            bit_cnt_d = BW'(DATA_WIDTH);
`ifdef BIPHASE_PREAMBLE_EN
            state_d   = PREAMBLE;
            pre_cnt_d = 3'd0;
            level_d   = level ^ PREAMBLE_TOGGLES[PREAMBLE_HALF_CELLS-1];
`else
            state_d   = FIRST_HALF;
            level_d   = ~level;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            level <= 1'b0;
        end else begin
            state <= state_d;
            level <= level_d;
        end
        shreg   <= shreg_d;
        bit_cnt <= bit_cnt_d;
`ifdef BIPHASE_PREAMBLE_EN
        pre_cnt <= pre_cnt_d;
`endif
    end

    assign biphase_out    = level;
    assign data_ready_out = ready && !rst;
    assign busy_out       = (state != IDLE) && !rst;
    assign frame_done_out = last_half && !rst;

endmodule

// File: tb/tb_biphase_mark_tx.sv
// Bench for biphase_mark_tx: a 4-bit/2-clock instance and a 20-bit/1-clock instance
// checked against a half-cell level model; honours BIPHASE_PREAMBLE_EN.
module tb_biphase_mark_tx;

`ifdef BIPHASE_PREAMBLE_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  d0;
    logic        v0;
    logic        rdy0, bp0, busy0, fd0;
    logic [19:0] d1;
    logic        v1;
    logic        rdy1, bp1, busy1, fd1;
    logic        sel;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    logic ml[2];

    always #5 clk = ~clk;

    biphase_mark_tx #(.DATA_WIDTH(4), .HALF_BIT_CLKS(2)) dut0 (
        .clk(clk), .rst(rst), .data_in(d0), .data_valid_in(v0),
        .data_ready_out(rdy0), .biphase_out(bp0), .busy_out(busy0), .frame_done_out(fd0)
    );

    biphase_mark_tx #(.DATA_WIDTH(20), .HALF_BIT_CLKS(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(d1), .data_valid_in(v1),
        .data_ready_out(rdy1), .biphase_out(bp1), .busy_out(busy1), .frame_done_out(fd1)
    );

    logic m_bp, m_busy, m_fd, m_rdy;
    assign m_bp   = sel ? bp1   : bp0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_fd   = sel ? fd1   : fd0;
    assign m_rdy  = sel ? rdy1  : rdy0;

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        if (sel) begin
            v1 = v; d1 = d[19:0]; v0 = 1'b0;
        end else begin
            v0 = v; d0 = d[3:0]; v1 = 1'b0;
        end
    endtask

    // Expected line level for every clock of a word: each bit is a toggle at cell
    // start, plus a mid-cell toggle for a 1, each half-cell held for h clocks.
    task automatic model(input logic [31:0] w, input int dw, input int h);
        logic       lvl;
        logic [7:0] tog;
        tog = 8'b1000_1000;
        lvl = ml[sel];
        exp_q.delete();
        if (PRE) begin
            for (int k = 0; k < 8; k++) begin
                if (tog[7-k]) lvl = ~lvl;
                repeat (h) exp_q.push_back(lvl);
            end
        end
        for (int i = dw - 1; i >= 0; i--) begin
            lvl = ~lvl;
            repeat (h) exp_q.push_back(lvl);
            if (w[i]) lvl = ~lvl;
            repeat (h) exp_q.push_back(lvl);
        end
        ml[sel] = lvl;
    endtask

    task automatic frame(input logic [31:0] w, input bit chain, input logic [31:0] nw, input bit rnd);
        int dw, h, t;
        dw = sel ? 20 : 4;
        h  = sel ? 1 : 2;
        t  = 2 * dw * h + (PRE ? 8 * h : 0);
        model(w, dw, h);
        drive(1'b1, w);
        for (int c = 0; c < t; c++) begin
            @(negedge clk);
            chk("line", m_bp, exp_q[c]);
            chk("busy", m_busy, 1'b1);
            chk("frame_done", m_fd, c == t - 1);
            chk("ready", m_rdy, c == t - 1);
            if (c == t - 1) drive(chain, nw);
            else drive(rnd ? 1'($urandom_range(0, 1)) : 1'b0, $urandom);
        end
        if (!chain) begin
            @(negedge clk);
            chk("idle_busy", m_busy, 1'b0);
            chk("idle_ready", m_rdy, 1'b1);
            chk("idle_line", m_bp, ml[sel]);
            chk("idle_fd", m_fd, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] w, nw;
        bit          ch;
        int          off;
        sel = 1'b0;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        ml[0] = 1'b0; ml[1] = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_line0", bp0, 1'b0);
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_fd0", fd0, 1'b0);
        chk("rst_ready0", rdy0, 1'b0);
        chk("rst_line1", bp1, 1'b0);
        chk("rst_ready1", rdy1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready0", rdy0, 1'b1);
        chk("post_rst_ready1", rdy1, 1'b1);
        chk("post_rst_busy0", busy0, 1'b0);

        sel = 1'b0;
        frame(32'hA, 1'b0, 32'h0, 1'b0);
        frame(32'h0, 1'b1, 32'hF, 1'b1);
        frame(32'hF, 1'b0, 32'h0, 1'b1);
        w = $urandom;
        for (int i = 0; i < 8; i++) begin
            nw = $urandom;
            ch = (i != 7) && 1'($urandom_range(0, 1));
            frame(w, ch, nw, 1'b1);
            w = nw;
        end

        sel = 1'b1;
        frame(32'hAAAAA, 1'b0, 32'h0, 1'b0);
        w = $urandom;
        for (int i = 0; i < 3; i++) begin
            nw = $urandom;
            ch = (i != 2);
            frame(w, ch, nw, 1'b1);
            w = nw;
        end

        // Abort a 20'hFFFFF frame with a one-cycle reset at the start of bit 2.
        model(32'hFFFFF, 20, 1);
        off = (PRE ? 8 : 0) + 4;
        drive(1'b1, 32'hFFFFF);
        for (int c = 0; c < off; c++) begin
            @(negedge clk);
            chk("abort_line", bp1, exp_q[c]);
            drive(1'b0, 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_line_rst", bp1, 1'b0);
        chk("abort_busy_rst", busy1, 1'b0);
        chk("abort_fd_rst", fd1, 1'b0);
        chk("abort_ready_rst", rdy1, 1'b0);
        rst = 1'b0;
        ml[0] = 1'b0; ml[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_ready", rdy1, 1'b1);
            chk("abort_busy", busy1, 1'b0);
            chk("abort_fd", fd1, 1'b0);
            chk("abort_line", bp1, 1'b0);
        end

        // A handshake coinciding with reset is dropped.
        sel = 1'b0;
        rst = 1'b1;
        drive(1'b1, 32'h5);
        @(negedge clk);
        chk("rst_hs_busy", busy0, 1'b0);
        chk("rst_hs_ready", rdy0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 32'h0);
        @(negedge clk);
        chk("rst_hs_busy2", busy0, 1'b0);
        chk("rst_hs_ready2", rdy0, 1'b1);
        chk("rst_hs_line", bp0, 1'b0);

        frame(32'hA, 1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
